sm_add_arbiter: RTL and testbench

Arbitration and sequencing controller that shares one `sign_magnitude_adder` instance between two independent requesters. Each requester presents a sign-magnitude operand pair with a level request. The arbiter grants round-robin, registers the operands, captures the sum, and returns it with a one-cycle acknowledge. It sits between operand sources (switch-capture logic, a test sequencer) and the display path, which reads `result`/`result_src` in place of a direct adder output.

---
 rtl/sm_arb_pkg.sv | 25 ++
 rtl/sign_magnitude_adder.sv | 54 +++++
 rtl/sm_add_arbiter.sv | 155 +++++++++++++++
 tb/tb_sm_add_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_arb_pkg
// Description : Shared types and constants for the sign-magnitude adder
//               arbiter: FSM state encoding, requester count and the
//               requester index type.
// Revision    : 1.0  initial release
// ============================================================================
package sm_arb_pkg;

    // Number of requesters sharing the adder.
    localparam int REQ_N = 2;

    // Index of a requester (0 .. REQ_N-1).
    typedef logic [$clog2(REQ_N)-1:0] req_idx_t;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage : sm_arb_pkg
`default_nettype wire

// File: rtl/sign_magnitude_adder.sv
`default_nettype none
// ============================================================================
// Module      : sign_magnitude_adder
// Description : Purely combinational sign-magnitude adder. Bit N-1 is the
//               sign (1 = negative), bits N-2:0 the magnitude.
//               - equal signs: magnitudes add modulo 2^(N-1), sign kept
//               - different signs: larger minus smaller, sign of the larger
//               - equal magnitudes, different signs: sign of b (may give -0)
//               No overflow detection.
// Ports       : i_a, i_b  in  N  operands
//               o_sum     out N  sum
// Revision    : 1.0  initial release
// ============================================================================
module sign_magnitude_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum
);

    logic         w_sa;
    logic         w_sb;
    logic [N-2:0] w_ma;
    logic [N-2:0] w_mb;
    logic [N-2:0] w_mag;
    logic         w_sign;

    assign w_sa = i_a[N-1];
    assign w_sb = i_b[N-1];
    assign w_ma = i_a[N-2:0];
    assign w_mb = i_b[N-2:0];

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        if (w_sa == w_sb) begin
            w_mag  = w_ma + w_mb;   // wraps silently
            w_sign = w_sa;
        end else if (w_ma > w_mb) begin
            w_mag  = w_ma - w_mb;
            w_sign = w_sa;
        end else begin
            // Covers |b| > |a| and the tie; a tie yields magnitude 0 with
            // b's sign, which is where -0 comes from.
            w_mag  = w_mb - w_ma;
            w_sign = w_sb;
        end
    end

    assign o_sum = {w_sign, w_mag};

endmodule : sign_magnitude_adder
`default_nettype wire

// File: rtl/sm_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sm_add_arbiter
// Description : Shares one sign_magnitude_adder between two requesters.
//               Round-robin grant in IDLE, operand capture, sum capture in
//               EXEC, one-cycle acknowledge after RESP. All outputs are
//               registered.
// Ports       : clk         in  1  system clock
//               reset       in  1  synchronous active-high reset
//               req0/req1   in  1  request levels
//               a0,b0,a1,b1 in  N  sign-magnitude operands
//               ack0/ack1   out 1  one-cycle completion pulse
//               result      out N  last completed sum
//               result_src  out 1  requester that produced result
//               busy        out 1  FSM not in IDLE
// Revision    : 1.0  initial release
// ============================================================================
module sm_add_arbiter
    import sm_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic [N-1:0] result,
    output logic         result_src,
    output logic         busy
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_t         r_state;
    req_idx_t           r_gnt;
    req_idx_t           r_last_gnt;
    logic [N-1:0]       r_op_a;
    logic [N-1:0]       r_op_b;
    logic [N-1:0]       r_result;
    req_idx_t           r_result_src;
    logic [REQ_N-1:0]   r_ack;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    arb_state_t         w_state_nxt;
    logic [REQ_N-1:0]   w_req;
    logic               w_grant;
    req_idx_t           w_gnt_sel;
    logic [N-1:0]       w_sum;
    logic               w_load_result;
    logic [REQ_N-1:0]   w_ack_d;
    logic               w_busy_d;

    assign w_req = {req1, req0};

    // Under contention the requester that did not win last time gets it;
    // otherwise the single active requester wins.
    assign w_gnt_sel = (w_req[0] && w_req[1]) ? ~r_last_gnt : req_idx_t'(w_req[1]);
    assign w_grant   = (r_state == IDLE) && (|w_req);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (values loaded into the output registers)
    // ------------------------------------------------------------------
    always_comb begin
        w_load_result = 1'b0;
        w_ack_d       = '0;
        w_busy_d      = (w_state_nxt != IDLE);
        case (r_state)
            EXEC:    w_load_result = 1'b1;
            RESP:    w_ack_d[r_gnt] = 1'b1;
            default: w_load_result = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared adder, fed only from the captured operands
    // ------------------------------------------------------------------
    sign_magnitude_adder #(
        .N (N)
    ) u_adder (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_sum (w_sum)
    );

    // ------------------------------------------------------------------
    // Grant, operand, result and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt        <= '0;
            r_last_gnt   <= '1;   // requester 0 wins the first contention
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_result_src <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt      <= w_gnt_sel;
                r_last_gnt <= w_gnt_sel;
                r_op_a     <= (w_gnt_sel == req_idx_t'(1)) ? a1 : a0;
                r_op_b     <= (w_gnt_sel == req_idx_t'(1)) ? b1 : b0;
            end
            if (w_load_result) begin
                r_result     <= w_sum;
                r_result_src <= r_gnt;
            end
            r_ack  <= w_ack_d;
            r_busy <= w_busy_d;
        end
    end

    assign ack0       = r_ack[0];
    assign ack1       = r_ack[1];
    assign result     = r_result;
    assign result_src = r_result_src;
    assign busy       = r_busy;

endmodule : sm_add_arbiter
`default_nettype wire

// File: tb/tb_sm_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_add_arbiter
// Description : Directed self-checking bench for sm_add_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sm_add_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         ack0;
    logic         ack1;
    logic [N-1:0] result;
    logic         result_src;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;

    sm_add_arbiter #(
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .a0         (a0),
        .b0         (b0),
        .req1       (req1),
        .a1         (a1),
        .b1         (b1),
        .ack0       (ack0),
        .ack1       (ack1),
        .result     (result),
        .result_src (result_src),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs change and outputs are
    // sampled here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete uncontended transaction from requester idx.
    // Edge k samples the request; result valid after k+1; ack after k+2.
    task automatic do_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_sum, input string tag);
        if (idx == 0) begin req0 = 1'b1; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; a1 = a; b1 = b; end
        tick();                                   // edge k
        check({tag, "_busy_k"}, 8'(busy), 8'd1);
        check({tag, "_noack_k"}, 8'({ack1, ack0}), 8'd0);
        tick();                                   // edge k+1
        check({tag, "_result"}, 8'(result), 8'(exp_sum));
        check({tag, "_src"}, 8'(result_src), 8'(idx));
        check({tag, "_noack_k1"}, 8'({ack1, ack0}), 8'd0);
        tick();                                   // edge k+2
        check({tag, "_ack"}, 8'({ack1, ack0}), (idx == 0) ? 8'd1 : 8'd2);
        check({tag, "_idle_busy"}, 8'(busy), 8'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();                                   // edge k+3
        check({tag, "_ack_gone"}, 8'({ack1, ack0}), 8'd0);
        check({tag, "_busy_after"}, 8'(busy), 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0; a0 = '0; b0 = '0;
        req1  = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---------------- reset state ----------------
        check("rst_ack",    8'({ack1, ack0}), 8'd0);
        check("rst_busy",   8'(busy), 8'd0);
        check("rst_result", 8'(result), 8'd0);
        check("rst_src",    8'(result_src), 8'd0);

        // ---------------- single request, +3 + +2 ----------------
        do_op(0, 4'b0011, 4'b0010, 4'b0101, "single0");

        // ---------------- mixed signs, +3 + -5 = -2 ----------------
        do_op(1, 4'b0011, 4'b1101, 4'b1010, "mixed1");

        // ---------------- contention from reset ----------------
        reset = 1'b1;
        req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0001;
        req1 = 1'b1; a1 = 4'b1010; b1 = 4'b1001;
        tick();
        reset = 1'b0;
        tick();                                   // edge k: grant 0
        check("cont_busy_k", 8'(busy), 8'd1);
        tick();                                   // k+1
        check("cont_res0", 8'(result), 8'b0010);
        check("cont_src0", 8'(result_src), 8'd0);
        tick();                                   // k+2
        check("cont_ack0", 8'({ack1, ack0}), 8'd1);
        req0 = 1'b0;
        tick();                                   // k+3: grant 1
        check("cont_gap_noack", 8'({ack1, ack0}), 8'd0);
        check("cont_busy_k3", 8'(busy), 8'd1);
        tick();                                   // k+4
        check("cont_res1", 8'(result), 8'b1011);
        check("cont_src1", 8'(result_src), 8'd1);
        tick();                                   // k+5
        check("cont_ack1", 8'({ack1, ack0}), 8'd2);
        req1 = 1'b0;
        tick();

        // ---------------- wrap and equal magnitudes ----------------
        do_op(0, 4'b0111, 4'b0001, 4'b0000, "wrap");
        do_op(1, 4'b1011, 4'b0011, 4'b0000, "eqmag_pos");
        do_op(0, 4'b0011, 4'b1011, 4'b1000, "negzero");

        // ---------------- reset during EXEC ----------------
        req0 = 1'b1; a0 = 4'b0010; b0 = 4'b0001;
        tick();                                   // grant, now in EXEC
        check("rexec_busy", 8'(busy), 8'd1);
        reset = 1'b1;
        tick();
        check("rexec_result", 8'(result), 8'd0);
        check("rexec_busy0", 8'(busy), 8'd0);
        check("rexec_noack", 8'({ack1, ack0}), 8'd0);
        reset = 1'b0;
        tick();                                   // held req re-sampled
        check("rexec_reserve_busy", 8'(busy), 8'd1);
        check("rexec_noack2", 8'({ack1, ack0}), 8'd0);
        tick();
        check("rexec_result2", 8'(result), 8'b0011);
        check("rexec_noack3", 8'({ack1, ack0}), 8'd0);
        tick();
        check("rexec_ack", 8'({ack1, ack0}), 8'd1);
        req0 = 1'b0;
        tick();
        check("rexec_done", 8'(busy), 8'd0);

        // ---------------- req0 held, req1 toggling ----------------
        // last grant was 0. Grants at k, k+3, k+6, k+9 with req1 high at
        // k and k+6 only: 1,0,1,0. Acks land at offsets 2,5,8,11.
        req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0010;   // +3
        req1 = 1'b1; a1 = 4'b0101; b1 = 4'b0001;   // +6
        for (int c = 0; c < 12; c++) begin
            tick();
            req1 = ((c + 1) % 2) == 0;
            check($sformatf("hold_ack1_c%0d", c), 8'(ack1), ((c % 6) == 2) ? 8'd1 : 8'd0);
            check($sformatf("hold_ack0_c%0d", c), 8'(ack0), ((c % 6) == 5) ? 8'd1 : 8'd0);
            check($sformatf("hold_busy_c%0d", c), 8'(busy), ((c % 3) == 2) ? 8'd0 : 8'd1);
            check($sformatf("hold_excl_c%0d", c), 8'(ack0 & ack1), 8'd0);
            if ((c % 6) == 2) check($sformatf("hold_res1_c%0d", c), 8'(result), 8'b0110);
            if ((c % 6) == 5) check($sformatf("hold_res0_c%0d", c), 8'(result), 8'b0011);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("hold_end_busy", 8'(busy), 8'd0);
        check("hold_end_ack", 8'({ack1, ack0}), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_sm_add_arbiter
`default_nettype wire
